// File: rtl/alu32_if.sv
// Operand/control and result/flag bundle between the decoder-side driver and the ALU.
interface alu32_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       ALUControl;
  logic [WIDTH-1:0] Result;
  logic [3:0]       ALUFlags;

  modport master (
    output a, b, ALUControl,
    input  Result, ALUFlags
  );

  modport slave (
    input  a, b, ALUControl,
    output Result, ALUFlags
  );
endinterface

// File: rtl/alu32.sv
// Execute-stage ALU: ADD/SUB/AND/OR with ARM {N,Z,C,V} flags, registered once.
module alu32 #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset,
  alu32_if.slave  bus
);

  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_result;
  logic [3:0]       w_flags;
  logic             w_arith;
  logic             w_v;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  // One adder serves ADD and SUB; SUB inverts b and injects the carry-in.
  assign w_b_op  = bus.ALUControl[0] ? ~bus.b : bus.b;
  assign w_sum   = {1'b0, bus.a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, bus.ALUControl[0]};
  assign w_arith = ~bus.ALUControl[1];

  // Operation select.
  always_comb begin
    w_result = {WIDTH{1'b0}};
    case (bus.ALUControl)
      2'b00:   w_result = w_sum[WIDTH-1:0];
      2'b01:   w_result = w_sum[WIDTH-1:0];
      2'b10:   w_result = bus.a & bus.b;
      2'b11:   w_result = bus.a | bus.b;
      default: w_result = {WIDTH{1'b0}};
    endcase
  end

  // Signed overflow: effective operands share a sign that the sum does not.
  assign w_v = w_arith
             & (bus.a[WIDTH-1] == (bus.b[WIDTH-1] ^ bus.ALUControl[0]))
             & (w_sum[WIDTH-1] != bus.a[WIDTH-1]);

  assign w_flags = {w_result[WIDTH-1],
                    (w_result == {WIDTH{1'b0}}),
                    w_arith & w_sum[WIDTH],
                    w_v};

  // Result and flags captured together; reset forces both to zero (Z included).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= {WIDTH{1'b0}};
      r_flags  <= 4'b0000;
    end else begin
      r_result <= w_result;
      r_flags  <= w_flags;
    end
  end

  assign bus.Result   = r_result;
  assign bus.ALUFlags = r_flags;

endmodule

// File: tb/tb_alu32.sv
// Directed-vector bench for alu32 with hand-computed results and flags.
module tb_alu32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu32_if #(.WIDTH(32)) bus ();

  alu32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic [1:0] op);
    bus.a          = av;
    bus.b          = bv;
    bus.ALUControl = op;
  endtask

  task automatic check(input string tag, input logic [31:0] exp_r, input logic [3:0] exp_f);
    checks++;
    assert (bus.Result === exp_r) else begin
      errors++;
      $error("FAIL %s Result observed %h expected %h", tag, bus.Result, exp_r);
    end
    checks++;
    assert (bus.ALUFlags === exp_f) else begin
      errors++;
      $error("FAIL %s ALUFlags observed %b expected %b", tag, bus.ALUFlags, exp_f);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] av, input logic [31:0] bv,
                      input logic [1:0] op, input logic [31:0] exp_r, input logic [3:0] exp_f);
    @(negedge clk);
    drive(av, bv, op);
    @(posedge clk);
    #1;
    check(tag, exp_r, exp_f);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(32'h0000_0000, 32'h0000_0000, 2'b00);
    #1;
    check("reset_state", 32'h0000_0000, 4'b0000);

    @(negedge clk);
    reset = 1'b0;

    step("add_basic",  32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'b00, 32'h3FFF_FFFE, 4'b0000);
    step("and_basic",  32'hFF0F_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFF0F_FFFF, 4'b1000);
    step("or_basic",   32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b11, 32'hFFFF_FFFF, 4'b1000);
    step("sub_5m5",    32'h0000_0005, 32'h0000_0005, 2'b01, 32'h0000_0000, 4'b0110);
    step("sub_0m1",    32'h0000_0000, 32'h0000_0001, 2'b01, 32'hFFFF_FFFF, 4'b1000);
    step("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 4'b1001);
    step("add_carry",  32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'h0000_0000, 4'b0110);
    step("sub_ovf",    32'h8000_0000, 32'h0000_0001, 2'b01, 32'h7FFF_FFFF, 4'b0011);
    step("and_zero",   32'hAAAA_AAAA, 32'h5555_5555, 2'b10, 32'h0000_0000, 4'b0100);

    // Back-to-back: new inputs right after each edge, outputs one cycle behind.
    @(negedge clk);
    drive(32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'b00);
    @(posedge clk);
    #1;
    check("stream_add", 32'h3FFF_FFFE, 4'b0000);
    drive(32'hFF0F_FFFF, 32'hFFFF_FFFF, 2'b10);
    @(posedge clk);
    #1;
    check("stream_and", 32'hFF0F_FFFF, 4'b1000);
    drive(32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b11);
    @(posedge clk);
    #1;
    check("stream_or", 32'hFFFF_FFFF, 4'b1000);

    // Asynchronous reset between edges, held across an edge, then released.
    step("pre_reset", 32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 4'b1001);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", 32'h0000_0000, 4'b0000);
    @(posedge clk);
    #1;
    check("reset_held", 32'h0000_0000, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset", 32'h8000_0000, 4'b1001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
